// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the MIPS execution sequencer: FSM state encoding,
// the halt opcode and the stop-condition helper used on every RUN tick.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_HALT = 2'b11
    } exec_state_t;

    // syscall encoding; the core treats it as "stop here"
    localparam logic [31:0] HALT_INSN = 32'h0000_000C;

    // True when the instruction at pc must not be executed in RUN mode.
    function automatic logic stop_hit(
        input logic        bp_en,
        input logic [31:0] pc,
        input logic [31:0] bp_addr,
        input logic [31:0] insn
    );
        return (bp_en && (pc == bp_addr)) || (insn == HALT_INSN);
    endfunction

endpackage

// File: rtl/run_tick_div.sv
// Free-running divider for RUN mode: counts 0..RUN_DIV-1 while enabled and
// flags the terminal count. clr returns the count to zero and masks the tick.
module run_tick_div #(
    parameter int RUN_DIV = 50_000_000,
    parameter int DIV_W   = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [DIV_W-1:0] TERM_C = DIV_W'(RUN_DIV - 1);

    logic [DIV_W-1:0] div_r;
    logic             term_s;

    assign term_s = (div_r == TERM_C);
    assign tick   = en && !clr && term_s;

    // Divider register: wraps on the terminal count, held at zero while cleared
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_r <= '0;
        end else if (clr) begin
            div_r <= '0;
        end else if (en) begin
            if (term_s) begin
                div_r <= '0;
            end else begin
                div_r <= div_r + DIV_W'(1);
            end
        end else begin
            div_r <= div_r;
        end
    end

endmodule

// File: rtl/cpu_exec_ctrl.sv
// Execution sequencer for the single-cycle MIPS core. Produces the one-cycle
// commit enable from the run switch (divided rate) or a step key press, stops
// on a PC breakpoint or halt instruction, and counts committed instructions.
module cpu_exec_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int RUN_DIV = 50_000_000,
    parameter int DIV_W   = 27,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      pc,
    input  logic [31:0]      instruction,
    output logic             cpu_ce,
    output logic [1:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt
);

    exec_state_t      state_r;
    exec_state_t      state_s;
    logic             step_q_r;
    logic             step_rise_s;
    logic             run_active_s;
    logic             tick_s;
    logic             stop_s;
    logic             cpu_ce_r;
    logic             cpu_ce_s;
    logic             halted_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;

    assign step_rise_s  = step && !step_q_r;
    assign run_active_s = (state_r == ST_RUN) && run;
    assign stop_s       = stop_hit(bp_en, pc, bp_addr, instruction);

    assign state     = state_r;
    assign cpu_ce    = cpu_ce_r;
    assign halted    = halted_r;
    assign cycle_cnt = cnt_r;

    // Divider only runs while RUN is being held; any other cycle restarts it
    run_tick_div #(
        .RUN_DIV (RUN_DIV),
        .DIV_W   (DIV_W)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .clr   (!run_active_s),
        .en    (run_active_s),
        .tick  (tick_s)
    );

    // Next-state and commit decision; the pulse is registered with the state
    always_comb begin
        state_s  = state_r;
        cpu_ce_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (run) begin
                    state_s = ST_RUN;
                end else if (step_rise_s) begin
                    state_s  = ST_STEP;
                    cpu_ce_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_STEP: begin
                state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (!run) begin
                    state_s = ST_IDLE;
                end else if (tick_s) begin
                    if (stop_s) begin
                        state_s = ST_HALT;
                    end else begin
                        state_s  = ST_RUN;
                        cpu_ce_s = 1'b1;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_HALT: begin
                if (step_rise_s) begin
                    state_s  = ST_STEP;
                    cpu_ce_s = 1'b1;
                end else if (!run) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HALT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Saturating increment of the instruction count on each commit
    always_comb begin
        cnt_s = cnt_r;
        if (cpu_ce_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_s = cnt_r;
        end
    end

    // FSM state, commit pulse, halt flag and key history
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            cpu_ce_r <= 1'b0;
            halted_r <= 1'b0;
            step_q_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            cpu_ce_r <= cpu_ce_s;
            halted_r <= (state_s == ST_HALT);
            step_q_r <= step;
        end
    end

    // Instruction counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_s;
        end
    end

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// Scoreboard bench for cpu_exec_ctrl. Two instances share the stimulus:
// dut0 (RUN_DIV=4, 32-bit count) and dut1 (RUN_DIV=1, 4-bit count so the
// saturation is reached quickly). A mode-level reference model predicts each
// commit; a monitor pops and compares whenever a DUT presents cpu_ce.
module tb_cpu_exec_ctrl;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_STEP = 2;
    localparam int M_HALT = 3;

    logic        clk = 1'b0;
    logic        reset, run, step, bp_en;
    logic [31:0] bp_addr, pc, instruction;

    logic        ce0, h0, ce1, h1;
    logic [1:0]  st0, st1;
    logic [31:0] cnt0;
    logic [3:0]  cnt1;

    typedef struct {
        int     edge_n;
        longint cnt;
    } exp_t;

    exp_t   q0[$];
    exp_t   q1[$];
    int     edge_cnt = 0;
    int     m_mode[2]  = '{M_IDLE, M_IDLE};
    int     m_phase[2] = '{0, 0};
    bit     m_pstep[2] = '{1'b0, 1'b0};
    longint m_cnt[2]   = '{0, 0};
    int     rdiv[2]    = '{4, 1};
    longint cmax[2]    = '{64'h0000_0000_FFFF_FFFF, 64'd15};
    int     pulses[2]  = '{0, 0};
    int     n_cmp = 0;
    int     n_bad = 0;
    longint base_c;
    int     base_p;

    always #5 clk = ~clk;

    cpu_exec_ctrl #(.RUN_DIV(4), .DIV_W(3), .CNT_W(32)) dut0 (
        .clk(clk), .reset(reset), .run(run), .step(step), .bp_en(bp_en),
        .bp_addr(bp_addr), .pc(pc), .instruction(instruction),
        .cpu_ce(ce0), .state(st0), .halted(h0), .cycle_cnt(cnt0)
    );

    cpu_exec_ctrl #(.RUN_DIV(1), .DIV_W(2), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset), .run(run), .step(step), .bp_en(bp_en),
        .bp_addr(bp_addr), .pc(pc), .instruction(instruction),
        .cpu_ce(ce1), .state(st1), .halted(h1), .cycle_cnt(cnt1)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: what the sequencer should do at one clock edge
    task automatic model_edge(input int k);
        bit   rise;
        bit   pulse;
        exp_t e;
        rise  = step && !m_pstep[k];
        pulse = 1'b0;
        if (!reset) begin
            m_mode[k]  = M_IDLE;
            m_phase[k] = 0;
            m_cnt[k]   = 0;
            m_pstep[k] = 1'b0;
        end else begin
            m_pstep[k] = step;
            case (m_mode[k])
                M_IDLE: begin
                    if (run) begin
                        m_mode[k]  = M_RUN;
                        m_phase[k] = 0;
                    end else if (rise) begin
                        m_mode[k] = M_STEP;
                        pulse     = 1'b1;
                    end
                end
                M_STEP: m_mode[k] = M_IDLE;
                M_RUN: begin
                    if (!run) begin
                        m_mode[k]  = M_IDLE;
                        m_phase[k] = 0;
                    end else if (m_phase[k] == rdiv[k] - 1) begin
                        m_phase[k] = 0;
                        if ((bp_en && pc == bp_addr) || instruction == 32'h0000_000C)
                            m_mode[k] = M_HALT;
                        else
                            pulse = 1'b1;
                    end else begin
                        m_phase[k]++;
                    end
                end
                M_HALT: begin
                    if (rise) begin
                        m_mode[k] = M_STEP;
                        pulse     = 1'b1;
                    end else if (!run) begin
                        m_mode[k] = M_IDLE;
                    end
                end
                default: m_mode[k] = M_IDLE;
            endcase
            if (pulse) begin
                if (m_cnt[k] < cmax[k]) m_cnt[k]++;
                e.edge_n = edge_cnt;
                e.cnt    = m_cnt[k];
                if (k == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end
    endtask

    // Monitor: per-cycle state/count check and pulse scoreboard
    task automatic mon(input int k, input logic ce, input logic [1:0] st,
                       input logic h, input longint cnt);
        exp_t e;
        bit   has;
        has = 1'b0;
        if (k == 0 && q0.size() > 0) begin e = q0[0]; has = 1'b1; end
        if (k == 1 && q1.size() > 0) begin e = q1[0]; has = 1'b1; end
        chk($sformatf("state[%0d]", k), longint'(st), longint'(m_mode[k]));
        chk($sformatf("halted[%0d]", k), longint'(h), longint'(m_mode[k] == M_HALT));
        chk($sformatf("cycle_cnt[%0d]", k), cnt, m_cnt[k]);
        if (ce) begin
            pulses[k]++;
            chk($sformatf("pulse_expected[%0d]", k), longint'(has), 64'd1);
            if (has) begin
                chk($sformatf("pulse_edge[%0d]", k), longint'(edge_cnt), longint'(e.edge_n));
                chk($sformatf("pulse_cnt[%0d]", k), cnt, e.cnt);
                if (k == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
            end
        end else if (has && e.edge_n <= edge_cnt) begin
            chk($sformatf("pulse_missing[%0d]", k), 64'd0, 64'd1);
            if (k == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
        end
    endtask

    always @(posedge clk) begin
        edge_cnt++;
        model_edge(0);
        model_edge(1);
    end

    always @(negedge clk) begin
        mon(0, ce0, st0, h0, longint'(cnt0));
        mon(1, ce1, st1, h1, longint'(cnt1));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Cycles with pc following dut0's committed count, like a real core
    task automatic cyc_pc(input int n, input longint b);
        repeat (n) begin
            @(negedge clk);
            pc = 32'((m_cnt[0] - b) * 4);
        end
    endtask

    initial begin
        reset = 1'b0; run = 1'b1; step = 1'b0; bp_en = 1'b0;
        bp_addr = 32'h0000_0010; pc = 32'h0000_0100; instruction = 32'h0;

        // 1. reset overrides run
        cyc(3);
        chk("rst_state", longint'(st0), 64'd0);
        chk("rst_ce", longint'(ce0), 64'd0);
        chk("rst_cnt", longint'(cnt0), 64'd0);
        reset = 1'b1;
        cyc(1);
        chk("release_to_run", longint'(st0), 64'd1);
        cyc(3);
        chk("no_early_pulse", longint'(ce0), 64'd0);
        cyc(1);
        chk("first_run_pulse", longint'(ce0), 64'd1);
        run = 1'b0;
        cyc(2);

        // 2. held step key gives one pulse
        base_c = m_cnt[0]; base_p = pulses[0];
        step = 1'b1;
        cyc(10);
        step = 1'b0;
        cyc(2);
        chk("step_pulses", longint'(pulses[0] - base_p), 64'd1);
        chk("step_cnt", longint'(cnt0) - base_c, 64'd1);
        chk("step_idle", longint'(st0), 64'd0);

        // 3. free run, every 4th cycle
        base_c = m_cnt[0]; base_p = pulses[0];
        run = 1'b1;
        cyc(41);
        run = 1'b0;
        cyc(1);
        chk("run_stop_idle", longint'(st0), 64'd0);
        cyc(8);
        chk("run_pulses", longint'(pulses[0] - base_p), 64'd10);
        chk("run_cnt", longint'(cnt0) - base_c, 64'd10);

        // 4. breakpoint at 0x10, then step past it and resume
        bp_en = 1'b1;
        base_c = m_cnt[0];
        pc = 32'h0;
        run = 1'b1;
        cyc_pc(30, base_c);
        chk("bp_halted", longint'(h0), 64'd1);
        chk("bp_cnt", longint'(cnt0) - base_c, 64'd4);
        step = 1'b1;
        cyc_pc(3, base_c);
        chk("bp_step_cnt", longint'(cnt0) - base_c, 64'd5);
        chk("bp_resume_run", longint'(st0), 64'd1);
        step = 1'b0;
        cyc_pc(10, base_c);
        run = 1'b0; bp_en = 1'b0;
        cyc(2);

        // 5. halt instruction
        instruction = 32'h0000_000C;
        run = 1'b1;
        cyc(6);
        chk("halt_insn_state", longint'(st0), 64'd3);
        run = 1'b0;
        cyc(1);
        chk("halt_to_idle", longint'(st0), 64'd0);
        instruction = 32'h0;

        // 6. run wins over a simultaneous step rise; RUN_DIV=1; saturation
        run = 1'b1; step = 1'b1;
        cyc(1);
        chk("prio_run_state", longint'(st0), 64'd1);
        chk("prio_no_pulse", longint'(ce0), 64'd0);
        run = 1'b0; step = 1'b0;
        cyc(2);
        run = 1'b1;
        cyc(2);
        repeat (6) begin
            @(negedge clk);
            chk("div1_continuous", longint'(ce1), 64'd1);
        end
        chk("sat_cnt", longint'(cnt1), 64'd15);
        run = 1'b0;
        cyc(2);

        // randomized traffic
        repeat (1500) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) run = ~run;
            if ($urandom_range(0, 3) == 0) step = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) bp_en = ~bp_en;
            pc = 32'($urandom_range(0, 7)) * 32'd4;
            instruction = ($urandom_range(0, 9) == 0) ? 32'h0000_000C : 32'($urandom);
            reset = ($urandom_range(0, 299) != 0);
        end
        reset = 1'b1; run = 1'b0; step = 1'b0;
        cyc(5);
        chk("q0_drained", longint'(q0.size()), 64'd0);
        chk("q1_drained", longint'(q1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
